retire_obs_compare: RTL and testbench

Consumes the lockstep retirement pulse produced by the two-core clock synchroniser and compares the architectural observations of both core copies at each joint retirement. It counts retired instructions over a bounded window and latches the first observation mismatch (index and kind), giving the contract-synthesis harness a sticky verdict. The window ends with either a "distinguishable" result (mismatch) or an "indistinguishable" result (done).

---
 rtl/retire_obs_compare.sv | 92 +++++++++
 tb/tb_retire_obs_compare.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/retire_obs_compare.sv
// Lockstep retirement observer: compares the PC and memory observations of two core copies
// at each joint retirement and latches the first mismatch over a bounded window.
module retire_obs_compare #(
    parameter int XLEN       = 32,
    parameter int MAX_RETIRE = 64,
    parameter int CNT_W      = $clog2(MAX_RETIRE + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             retire_i,
    input  logic [1:0]       obs_mask_i,
    input  logic [XLEN-1:0]  pc_1_i,
    input  logic [XLEN-1:0]  pc_2_i,
    input  logic             mem_valid_1_i,
    input  logic             mem_valid_2_i,
    input  logic [XLEN-1:0]  mem_addr_1_i,
    input  logic [XLEN-1:0]  mem_addr_2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             mismatch_o,
    output logic [CNT_W-1:0] mismatch_idx_o,
    output logic [1:0]       mismatch_kind_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MISMATCH = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETIRE);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] idx_q;
    logic [1:0]       kind_q;

    logic             pc_diff;
    logic             mem_diff;
    logic [CNT_W-1:0] cnt_d;

    // retire_i is a level strobe with no back-pressure: every cycle it is high while in RUN
    // counts as exactly one joint retirement; it is never stalled or acknowledged.
    assign pc_diff  = obs_mask_i[0] & (pc_1_i != pc_2_i);
    assign mem_diff = obs_mask_i[1] &
                      ((mem_valid_1_i != mem_valid_2_i) |
                       (mem_valid_1_i & mem_valid_2_i & (mem_addr_1_i != mem_addr_2_i)));
    assign cnt_d    = cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            kind_q  <= '0;
        end else if (start_i) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            idx_q   <= '0;
            kind_q  <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (retire_i) begin
                        cnt_q <= cnt_d;
                        // A mismatch on the last retirement wins over window completion.
                        if (pc_diff || mem_diff) begin
                            kind_q  <= {mem_diff, pc_diff};
                            idx_q   <= cnt_q;
                            state_q <= S_MISMATCH;
                        end else if (cnt_d == MAX_CNT) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o          = (state_q == S_RUN);
    assign done_o          = (state_q == S_DONE);
    assign mismatch_o      = (state_q == S_MISMATCH);
    assign mismatch_idx_o  = idx_q;
    assign mismatch_kind_o = kind_q;
    assign retire_cnt_o    = cnt_q;

endmodule

// File: tb/tb_retire_obs_compare.sv
// Directed and randomized checks of retire_obs_compare with MAX_RETIRE=4, using a
// reference model that feeds an expected-result queue.
module tb_retire_obs_compare;

    localparam int XLEN = 32;
    localparam int MAXR = 4;
    localparam int CW   = 3;
    localparam int W    = 3 + CW + 2 + CW;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            start_i = 1'b0;
    logic            retire_i = 1'b0;
    logic [1:0]      obs_mask_i = 2'b11;
    logic [XLEN-1:0] pc_1_i = '0;
    logic [XLEN-1:0] pc_2_i = '0;
    logic            mem_valid_1_i = 1'b0;
    logic            mem_valid_2_i = 1'b0;
    logic [XLEN-1:0] mem_addr_1_i = '0;
    logic [XLEN-1:0] mem_addr_2_i = '0;
    logic            busy_o;
    logic            done_o;
    logic            mismatch_o;
    logic [CW-1:0]   mismatch_idx_o;
    logic [1:0]      mismatch_kind_o;
    logic [CW-1:0]   retire_cnt_o;

    retire_obs_compare #(.XLEN(XLEN), .MAX_RETIRE(MAXR)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .retire_i(retire_i),
        .obs_mask_i(obs_mask_i), .pc_1_i(pc_1_i), .pc_2_i(pc_2_i),
        .mem_valid_1_i(mem_valid_1_i), .mem_valid_2_i(mem_valid_2_i),
        .mem_addr_1_i(mem_addr_1_i), .mem_addr_2_i(mem_addr_2_i),
        .busy_o(busy_o), .done_o(done_o), .mismatch_o(mismatch_o),
        .mismatch_idx_o(mismatch_idx_o), .mismatch_kind_o(mismatch_kind_o),
        .retire_cnt_o(retire_cnt_o)
    );

    // clock/reset block
    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    // reference model state: 0 idle, 1 run, 2 mismatch, 3 done
    int m_state = 0;
    int m_cnt   = 0;
    int m_idx   = 0;
    int m_kind  = 0;

    function automatic logic [W-1:0] mk(input logic b, input logic d, input logic m,
                                        input int idx, input int kind, input int cnt);
        logic [CW-1:0] i3;
        logic [1:0]    k2;
        logic [CW-1:0] c3;
        i3 = idx[CW-1:0];
        k2 = kind[1:0];
        c3 = cnt[CW-1:0];
        return {b, d, m, i3, k2, c3};
    endfunction

    function automatic logic [W-1:0] obs_vec();
        return {busy_o, done_o, mismatch_o, mismatch_idx_o, mismatch_kind_o, retire_cnt_o};
    endfunction

    function automatic logic [W-1:0] model_vec();
        return mk(m_state == 1, m_state == 3, m_state == 2, m_idx, m_kind, m_cnt);
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_idx = 0; m_kind = 0;
    endtask

    task automatic model_step();
        logic pd, md;
        pd = obs_mask_i[0] & (pc_1_i != pc_2_i);
        md = obs_mask_i[1] & ((mem_valid_1_i ^ mem_valid_2_i) |
             (mem_valid_1_i & mem_valid_2_i & (mem_addr_1_i != mem_addr_2_i)));
        if (start_i) begin
            m_state = 1; m_cnt = 0; m_idx = 0; m_kind = 0;
        end else if (m_state == 1 && retire_i) begin
            if (pd || md) begin
                m_kind  = {30'd0, md, pd};
                m_idx   = m_cnt;
                m_cnt   = m_cnt + 1;
                m_state = 2;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == MAXR) m_state = 3;
            end
        end
    endtask

    // driver: one clock of stimulus; expectation pushed at drive time, popped after the edge
    task automatic cycle(input string tag, input logic st, input logic rt, input logic [1:0] mask,
                         input logic [XLEN-1:0] p1, input logic [XLEN-1:0] p2,
                         input logic v1, input logic v2,
                         input logic [XLEN-1:0] a1, input logic [XLEN-1:0] a2);
        start_i = st; retire_i = rt; obs_mask_i = mask;
        pc_1_i = p1; pc_2_i = p2; mem_valid_1_i = v1; mem_valid_2_i = v2;
        mem_addr_1_i = a1; mem_addr_2_i = a2;
        model_step();
        exp_q.push_back(model_vec());
        @(posedge clk_i);
        #1;
        check(tag, obs_vec(), exp_q.pop_front());
        start_i = 1'b0; retire_i = 1'b0;
    endtask

    task automatic do_start(input string tag);
        cycle(tag, 1'b1, 1'b0, 2'b11, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic clean_retire(input string tag, input logic [XLEN-1:0] pc);
        cycle(tag, 1'b0, 1'b1, 2'b11, pc, pc, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        // reset held: toggling start/retire must not move anything
        for (int i = 0; i < 3; i++) begin
            start_i = i[0]; retire_i = ~i[0];
            @(posedge clk_i);
            #1;
            check("reset_hold", obs_vec(), mk(0, 0, 0, 0, 0, 0));
        end
        start_i = 1'b0; retire_i = 1'b0;
        rst_ni = 1'b1;
        model_reset();
        clean_retire("idle_retire0", 32'h10);
        clean_retire("idle_retire1", 32'h14);
        check("idle_const", obs_vec(), mk(0, 0, 0, 0, 0, 0));

        // clean window
        do_start("clean_start");
        check("clean_start_const", obs_vec(), mk(1, 0, 0, 0, 0, 0));
        for (int i = 0; i < MAXR; i++) clean_retire("clean_ret", 32'h40 + 32'(4 * i));
        check("clean_done_const", obs_vec(), mk(0, 1, 0, 0, 0, 4));
        clean_retire("clean_extra", 32'h80);
        check("clean_hold_const", obs_vec(), mk(0, 1, 0, 0, 0, 4));

        // PC mismatch at index 1
        do_start("pc_start");
        clean_retire("pc_ret0", 32'hF0);
        cycle("pc_ret1", 1'b0, 1'b1, 2'b11, 32'h100, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0);
        check("pc_mm_const", obs_vec(), mk(0, 0, 1, 1, 1, 2));
        cycle("pc_after", 1'b0, 1'b1, 2'b11, 32'h1, 32'h2, 1'b1, 1'b0, 32'h0, 32'h0);
        clean_retire("pc_after2", 32'h3);
        check("pc_hold_const", obs_vec(), mk(0, 0, 1, 1, 1, 2));

        // memory mismatch and masking
        do_start("mem_start");
        cycle("mem_masked", 1'b0, 1'b1, 2'b01, 32'h20, 32'h20, 1'b1, 1'b0, 32'h2000, 32'h0);
        cycle("mem_valid_diff", 1'b0, 1'b1, 2'b10, 32'h24, 32'h28, 1'b1, 1'b0, 32'h2000, 32'h0);
        check("mem_mm_const", obs_vec(), mk(0, 0, 1, 1, 2, 2));
        do_start("both_start");
        cycle("both_noaddr", 1'b0, 1'b1, 2'b10, 32'h30, 32'h30, 1'b0, 1'b0, 32'h5, 32'h9);
        cycle("both_diff", 1'b0, 1'b1, 2'b11, 32'h30, 32'h34, 1'b1, 1'b1, 32'h2000, 32'h2004);
        check("both_mm_const", obs_vec(), mk(0, 0, 1, 1, 3, 2));

        // mismatch on the final retirement beats done
        do_start("last_start");
        for (int i = 0; i < MAXR - 1; i++) clean_retire("last_clean", 32'h60);
        cycle("last_mm", 1'b0, 1'b1, 2'b01, 32'h60, 32'h64, 1'b0, 1'b0, 32'h0, 32'h0);
        check("last_mm_const", obs_vec(), mk(0, 0, 1, 3, 1, 4));

        // start from MISMATCH clears the verdict
        do_start("restart_mm");
        check("restart_mm_const", obs_vec(), mk(1, 0, 0, 0, 0, 0));

        // start wins over retire in RUN
        clean_retire("sr_ret", 32'h70);
        cycle("sr_both", 1'b1, 1'b1, 2'b11, 32'h70, 32'h74, 1'b0, 1'b0, 32'h0, 32'h0);
        check("sr_const", obs_vec(), mk(1, 0, 0, 0, 0, 0));

        // asynchronous reset mid-window
        clean_retire("mid_ret0", 32'h90);
        clean_retire("mid_ret1", 32'h94);
        rst_ni = 1'b0;
        #2;
        check("mid_reset_async", obs_vec(), mk(0, 0, 0, 0, 0, 0));
        #1;
        rst_ni = 1'b1;
        model_reset();
        do_start("mid_start");
        for (int i = 0; i < MAXR; i++) clean_retire("mid_clean", 32'hA0);
        check("mid_done_const", obs_vec(), mk(0, 1, 0, 0, 0, 4));

        // randomized mix against the model
        for (int i = 0; i < 60; i++) begin
            logic [XLEN-1:0] p1, a1;
            p1 = 32'($urandom_range(0, 3));
            a1 = 32'($urandom_range(0, 3));
            cycle("rand", ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  p1, ($urandom_range(0, 5) == 0) ? p1 + 1 : p1,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  a1, ($urandom_range(0, 5) == 0) ? a1 + 4 : a1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
